// File: rtl/sdram_half_arbiter.sv
// Shares the SDRAM controller port between the SD-card loader (writes) and
// playback (reads), and schedules ping-pong use of the two SDRAM halves.
module sdram_half_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_address,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_op_begun,
  input  logic              ld_done,
  output logic              ld_continue,
  input  logic              pb_req,
  input  logic [ADDR_W-1:0] pb_address,
  output logic              pb_op_begun,
  output logic [DATA_W-1:0] pb_rdata,
  output logic              pb_rdata_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              fill_half,
  output logic              underrun
);
  localparam int HALF_BIT = 23;
  localparam int CNT_W    = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GNT_LD, GNT_PB, WAIT_RD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              fill_half_q, fill_half_d;
  logic              play_half_q, play_half_d;
  logic              guard_q, guard_d;
  logic              ld_continue_q, ld_continue_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] pb_rdata_q, pb_rdata_d;
  logic              pb_rdata_valid_q, pb_rdata_valid_d;

  logic ld_ack, pb_ack, rd_done, pb_wins, cont_fire;

  // The SDRAM port is steered combinationally by whoever holds the grant.
  assign mem_req     = (state_q == GNT_LD) || (state_q == GNT_PB);
  assign mem_we      = (state_q == GNT_LD);
  assign mem_address = (state_q == GNT_LD) ? ld_address : pb_address;
  assign mem_wdata   = ld_data;
  assign ld_op_begun = ld_ack;
  assign pb_op_begun = pb_ack;

  assign ld_continue    = ld_continue_q;
  assign fill_half      = fill_half_q;
  assign underrun       = underrun_q;
  assign pb_rdata       = pb_rdata_q;
  assign pb_rdata_valid = pb_rdata_valid_q;

  always_comb begin
    ld_ack    = (state_q == GNT_LD) && mem_ack;
    pb_ack    = (state_q == GNT_PB) && mem_ack;
    // Read data may arrive together with the acknowledge.
    rd_done   = mem_rdata_valid && ((state_q == WAIT_RD) || pb_ack);
    pb_wins   = pb_req && (!ld_we || (starve_q < CNT_MAX));
    cont_fire = ld_done && (play_half_q == fill_half_q) && !guard_q;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pb_wins)    state_d = GNT_PB;
        else if (ld_we) state_d = GNT_LD;
      end
      GNT_LD:  if (mem_ack) state_d = IDLE;
      GNT_PB:  if (mem_ack) state_d = rd_done ? IDLE : WAIT_RD;
      WAIT_RD: if (mem_rdata_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    starve_d = starve_q;
    if (!ld_we || ld_ack)                     starve_d = '0;
    else if (pb_ack && (starve_q < CNT_MAX)) starve_d = starve_q + 1'b1;

    play_half_d   = pb_ack ? pb_address[HALF_BIT] : play_half_q;
    ld_continue_d = cont_fire;
    fill_half_d   = fill_half_q ^ cont_fire;
    // Guard stays set until the loader drops done, so a held done pulses once.
    guard_d       = ld_done && (guard_q || cont_fire);
    underrun_d    = underrun_q ||
                    (pb_req && (pb_address[HALF_BIT] == fill_half_q) && !ld_done);

    pb_rdata_valid_d = rd_done;
    pb_rdata_d       = rd_done ? mem_rdata : pb_rdata_q;
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      starve_q         <= '0;
      fill_half_q      <= 1'b0;
      play_half_q      <= 1'b0;
      guard_q          <= 1'b0;
      ld_continue_q    <= 1'b0;
      underrun_q       <= 1'b0;
      pb_rdata_q       <= '0;
      pb_rdata_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      starve_q         <= starve_d;
      fill_half_q      <= fill_half_d;
      play_half_q      <= play_half_d;
      guard_q          <= guard_d;
      ld_continue_q    <= ld_continue_d;
      underrun_q       <= underrun_d;
      pb_rdata_q       <= pb_rdata_d;
      pb_rdata_valid_q <= pb_rdata_valid_d;
    end
  end

endmodule

// File: tb/tb_sdram_half_arbiter.sv
// Bench for sdram_half_arbiter: directed scenarios plus random traffic, all
// compared against a transaction-level reference model of the arbiter.
module tb_sdram_half_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int SMAX = 8;
  localparam int NONE = 0, OWN_LD = 1, OWN_PB = 2;

  logic          clk50 = 1'b0;
  logic          reset_n;
  logic          ld_we, ld_done, pb_req, mem_ack, mem_rdata_valid;
  logic [AW-1:0] ld_address, pb_address;
  logic [DW-1:0] ld_data, mem_rdata;
  logic          ld_op_begun, ld_continue, pb_op_begun, pb_rdata_valid;
  logic          mem_req, mem_we, fill_half, underrun;
  logic [DW-1:0] pb_rdata, mem_wdata;
  logic [AW-1:0] mem_address;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the port, whether a read is outstanding,
  // and the half-scheduling bookkeeping.
  int            m_own;
  bit            m_rdwait, m_fill, m_play, m_guard, m_cont, m_unr, m_rv, m_la;
  int            m_starve;
  logic [DW-1:0] m_rd;

  bit o_ld_ack, o_pb_ack;
  int n_cont;

  sdram_half_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk50(clk50), .reset_n(reset_n),
    .ld_we(ld_we), .ld_address(ld_address), .ld_data(ld_data),
    .ld_op_begun(ld_op_begun), .ld_done(ld_done), .ld_continue(ld_continue),
    .pb_req(pb_req), .pb_address(pb_address), .pb_op_begun(pb_op_begun),
    .pb_rdata(pb_rdata), .pb_rdata_valid(pb_rdata_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .fill_half(fill_half), .underrun(underrun)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = NONE; m_rdwait = 0; m_starve = 0; m_fill = 0; m_play = 0;
    m_guard = 0; m_cont = 0; m_unr = 0; m_rv = 0; m_rd = '0; m_la = 0;
  endtask

  function automatic int pick_owner(bit preq, bit lreq, int starve);
    if (preq && (!lreq || starve < SMAX)) return OWN_PB;
    if (lreq) return OWN_LD;
    return NONE;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit la, pa, fire, got;
    la  = (m_own == OWN_LD) && mem_ack;
    pa  = (m_own == OWN_PB) && mem_ack;
    got = mem_rdata_valid && (pa || m_rdwait);
    m_rv = got;
    if (got) m_rd = mem_rdata;
    fire = ld_done && (m_play == m_fill) && !m_guard;
    if (pb_req && pb_address[23] == m_fill && !ld_done) m_unr = 1;
    m_cont = fire;
    if (fire) m_fill = !m_fill;
    m_guard = ld_done && (m_guard || fire);
    if (pa) m_play = pb_address[23];
    if (m_own == NONE && !m_rdwait) m_own = pick_owner(pb_req, ld_we, m_starve);
    else if (la) m_own = NONE;
    else if (pa) begin m_own = NONE; m_rdwait = !mem_rdata_valid; end
    else if (m_rdwait && mem_rdata_valid) m_rdwait = 0;
    if (!ld_we || la) m_starve = 0;
    else if (pa && m_starve < SMAX) m_starve++;
    m_la = la;
  endtask

  // Called at a falling edge with inputs applied; checks then moves on.
  task automatic tick();
    #1;
    o_ld_ack = ld_op_begun;
    o_pb_ack = pb_op_begun;
    n_cont += int'(ld_continue);
    chk("mem_req", mem_req, m_own != NONE);
    if (m_own != NONE) begin
      chk("mem_we", mem_we, m_own == OWN_LD);
      chk("mem_address", mem_address, (m_own == OWN_LD) ? ld_address : pb_address);
    end
    if (m_own == OWN_LD) chk("mem_wdata", mem_wdata, ld_data);
    chk("ld_op_begun", ld_op_begun, (m_own == OWN_LD) && mem_ack);
    chk("pb_op_begun", pb_op_begun, (m_own == OWN_PB) && mem_ack);
    chk("ld_continue", ld_continue, m_cont);
    chk("fill_half", fill_half, m_fill);
    chk("underrun", underrun, m_unr);
    chk("pb_rdata_valid", pb_rdata_valid, m_rv);
    chk("pb_rdata", pb_rdata, m_rd);
    model_step();
    @(negedge clk50);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pb_req = 1; pb_address = a;
    for (int i = 0; i < 8 && m_own != OWN_PB; i++) tick();
    mem_ack = 1; tick();
    pb_req = 0; mem_ack = 0; mem_rdata_valid = 1; mem_rdata = d; tick();
    mem_rdata_valid = 0; tick();
  endtask

  int pb_cnt, pb_before;

  initial begin
    reset_n = 0; ld_we = 0; ld_done = 0; pb_req = 0; mem_ack = 0;
    mem_rdata_valid = 0; ld_address = '0; pb_address = '0; ld_data = '0;
    mem_rdata = '0; n_cont = 0;
    model_reset();
    repeat (2) @(negedge clk50);
    reset_n = 1;
    chk("rst_fill_half", fill_half, 0);
    chk("rst_pb_rdata", pb_rdata, 0);
    tick();

    // Loader alone, acknowledged two cycles after the grant.
    ld_we = 1; ld_address = 25'h0000010; ld_data = 16'hBEEF;
    for (int i = 0; i < 8 && m_own != OWN_LD; i++) tick();
    repeat (2) tick();
    mem_ack = 1;
    #1;
    chk("ld_mem_we", mem_we, 1);
    chk("ld_mem_address", mem_address, 25'h0000010);
    chk("ld_mem_wdata", mem_wdata, 16'hBEEF);
    chk("ld_op_begun_pulse", ld_op_begun, 1);
    chk("ld_pb_op_begun_quiet", pb_op_begun, 0);
    tick();
    ld_we = 0; mem_ack = 0;
    #1 chk("ld_back_idle", mem_req, 0);
    tick();

    // Read path: ack one cycle after the grant, data three cycles later.
    pb_req = 1; pb_address = 25'h0800004;
    tick();
    mem_ack = 1; tick();
    pb_req = 0; mem_ack = 0; tick(); tick();
    mem_rdata_valid = 1; mem_rdata = 16'h1234; tick();
    mem_rdata_valid = 0;
    #1;
    chk("rd_data", pb_rdata, 16'h1234);
    chk("rd_valid_high", pb_rdata_valid, 1);
    tick();
    #1 chk("rd_valid_single", pb_rdata_valid, 0);
    tick();

    // Starvation: both requesters held, controller answers immediately.
    pb_req = 1; pb_address = 25'h0800000; ld_we = 1;
    ld_address = 25'h0000123; ld_data = 16'h5A5A;
    pb_cnt = 0; pb_before = -1;
    for (int i = 0; i < 60; i++) begin
      mem_ack = (m_own != NONE);
      mem_rdata_valid = (m_own == OWN_PB);
      mem_rdata = DW'($urandom);
      tick();
      if (o_pb_ack) pb_cnt++;
      if (o_ld_ack) begin pb_before = pb_cnt; ld_we = 0; end
      if (pb_before >= 0 && pb_cnt > pb_before) break;
    end
    chk("starve_pb_grants_before_ld", pb_before, SMAX);
    chk("starve_pb_resumes", pb_cnt > pb_before, 1);
    pb_req = 0; mem_ack = 0; mem_rdata_valid = 0;
    repeat (2) tick();

    // Ping-pong: continue pulse once playback enters the filled half.
    ld_done = 1; n_cont = 0;
    repeat (3) tick();
    chk("pp_no_pulse_before_entry", n_cont, 0);
    do_read(25'h0000000, 16'h0001);
    repeat (2) tick();
    chk("pp_pulse_count_1", n_cont, 1);
    chk("pp_fill_half_1", fill_half, 1);
    n_cont = 0;
    repeat (6) tick();
    chk("pp_no_double_pulse", n_cont, 0);
    ld_done = 0; tick();
    ld_done = 1; n_cont = 0;
    repeat (3) tick();
    chk("pp_wait_for_entry", n_cont, 0);
    do_read(25'h0800000, 16'h0002);
    repeat (2) tick();
    chk("pp_pulse_count_2", n_cont, 1);
    chk("pp_fill_half_0", fill_half, 0);

    // Underrun: read from the half still being written.
    chk("unr_still_clear", underrun, 0);
    ld_done = 0; tick();
    ld_done = 1;
    do_read(25'h0000000, 16'h0003);
    repeat (2) tick();
    chk("unr_fill_half_1", fill_half, 1);
    ld_done = 0;
    do_read(25'h0800000, 16'h0004);
    chk("unr_set", underrun, 1);
    ld_done = 1;
    do_read(25'h0000000, 16'h0005);
    do_read(25'h0800000, 16'h0006);
    chk("unr_sticky", underrun, 1);

    // Reset while the loader holds the grant without an acknowledge.
    ld_we = 1; ld_address = 25'h0000077; ld_data = 16'hCAFE;
    for (int i = 0; i < 8 && m_own != OWN_LD; i++) tick();
    tick();
    #1 chk("rst_pre_mem_req", mem_req, 1);
    #4 reset_n = 0;
    #1;
    chk("rst_mem_req_drops", mem_req, 0);
    chk("rst_fill_half_mid", fill_half, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ld_continue", ld_continue, 0);
    chk("rst_pb_rdata_valid", pb_rdata_valid, 0);
    chk("rst_pb_rdata_mid", pb_rdata, 0);
    model_reset();
    ld_we = 0; pb_req = 0; ld_done = 0;
    @(negedge clk50);
    reset_n = 1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (ld_we && m_la) ld_we = 0;
      else if (!ld_we && $urandom_range(3) == 0) begin
        ld_we = 1; ld_address = AW'($urandom); ld_data = DW'($urandom);
      end
      if (pb_req && o_pb_ack) pb_req = 0;
      else if (!pb_req && $urandom_range(2) == 0) begin
        pb_req = 1; pb_address = AW'($urandom);
      end
      mem_ack = (m_own != NONE) && ($urandom_range(2) == 0);
      mem_rdata_valid = (m_rdwait || (m_own == OWN_PB && mem_ack)) && ($urandom_range(2) == 0);
      mem_rdata = DW'($urandom);
      if ($urandom_range(15) == 0) ld_done = !ld_done;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_half_arbiter.md
Name: sdram_half_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: the SD-card block loader (writes) and the multimedia playback reader (reads).
- Schedules the ping-pong use of the two 8M-word SDRAM halves. It tracks which half the loader is filling and which half playback is reading.
- Issues the loader's "continue" pulse once playback has entered the freshly filled half.
- Flags underruns.

Parameters:
- ADDR_W, 25, SDRAM word-address width.
- DATA_W, 16, SDRAM word width.
- STARVE_MAX, 8, maximum consecutive playback grants while a loader write is pending; the loader must be granted after this many.

Ports:
- clk50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- ld_we  in  1  loader write request, held until acknowledged
- ld_address  in  ADDR_W  loader word address, with the half offset already applied
- ld_data  in  DATA_W  loader write data
- ld_op_begun  out  1  loader acknowledge: the write was accepted by the SDRAM
- ld_done  in  1  loader has finished its current half
- ld_continue  out  1  one-cycle pulse telling the loader to start the next half
- pb_req  in  1  playback read request, held until acknowledged
- pb_address  in  ADDR_W  playback word address; bit 23 selects the half
- pb_op_begun  out  1  playback acknowledge: the read was accepted
- pb_rdata  out  DATA_W  read data returned to playback
- pb_rdata_valid  out  1  one-cycle strobe qualifying pb_rdata
- mem_req  out  1  request to the SDRAM controller
- mem_we  out  1  1 = write, 0 = read
- mem_address  out  ADDR_W  address to the SDRAM controller
- mem_wdata  out  DATA_W  write data to the SDRAM controller
- mem_ack  in  1  SDRAM controller has begun the operation
- mem_rdata  in  DATA_W  read data from the SDRAM controller
- mem_rdata_valid  in  1  qualifies mem_rdata
- fill_half  out  1  half the loader is currently filling
- underrun  out  1  sticky playback-underrun flag

Behaviour:
- Reset (asynchronous, on reset_n = 0):
  - State goes to IDLE.
  - Cleared: fill_half, starve count, underrun, ld_continue, pb_rdata_valid.
  - pb_rdata goes to 0 and mem_req drops immediately.
  - Any in-flight operation is abandoned; there is no re-issue after reset.
- States: IDLE, GNT_LD, GNT_PB, WAIT_RD.
- IDLE:
  - If pb_req = 1 and (ld_we = 0 or starve count < STARVE_MAX): go to GNT_PB.
  - Otherwise, if ld_we = 1: go to GNT_LD.
  - If both requests arrive in the same cycle, playback wins unless the starve count has reached STARVE_MAX.
- mem_* drive and grant hold:
  - mem_* outputs are driven combinationally from the granted requester.
  - mem_req = 1 only while in GNT_LD or GNT_PB.
  - The grant is held until mem_ack.
- mem_ack in the granted state:
  - mem_ack is forwarded combinationally, in the same cycle, to the owner's op_begun. The non-owner's op_begun stays 0.
  - From GNT_LD: go to IDLE.
  - From GNT_PB: go to WAIT_RD.
- WAIT_RD:
  - Stay until mem_rdata_valid = 1.
  - On mem_rdata_valid, register mem_rdata into pb_rdata and pulse pb_rdata_valid one cycle later.
  - Then go to IDLE. At most one read is outstanding.
  - If mem_ack and mem_rdata_valid arrive in the same cycle, go directly from GNT_PB to IDLE and still deliver the data.
- Starve count:
  - Increments on each playback acknowledge while ld_we = 1.
  - Clears on a loader acknowledge or whenever ld_we = 0.
  - Saturates at STARVE_MAX.
- Half scheduling:
  - play_half = pb_address[23], sampled on each playback acknowledge; it resets to 0.
  - Condition: ld_done = 1, play_half == fill_half and the continue guard is clear. When it holds, pulse ld_continue for one cycle, toggle fill_half and set the guard.
  - The guard clears when ld_done is seen low. This prevents a double pulse while the loader's done output is still high.
- Underrun:
  - Set on a pb_req whose pb_address[23] == fill_half while ld_done = 0, i.e. playback is reading the half still being written.
  - Sticky until reset. The request itself is still serviced.
- Width: mem_address is passed through unmodified; the arbiter does no offset arithmetic.

Test Plan:
- Reset mid-write: assert GNT_LD with mem_ack held 0, then pull reset_n low -> mem_req = 0 in the same cycle; fill_half = 0 and underrun = 0.
- Loader alone: ld_we with ld_address = 0x0000010 and ld_data = 0xBEEF; mem_ack 2 cycles later -> mem_we = 1, address and data pass through, ld_op_begun pulses with mem_ack, state returns to IDLE.
- Read path: pb_req at 0x0800004; mem_ack at cycle 1; mem_rdata = 0x1234 valid at cycle 4 -> pb_rdata = 0x1234 and pb_rdata_valid high for exactly 1 cycle, one cycle after mem_rdata_valid.
- Starvation: pb_req and ld_we held continuously with an immediate mem_ack and rdata each time -> after 8 playback grants the 9th grant goes to the loader; playback resumes afterwards.
- Ping-pong:
  - ld_done high and pb_address = 0x0000000 acknowledged -> one ld_continue pulse and fill_half = 1.
  - Holding ld_done high produces no second pulse.
  - Drop ld_done, raise it again, then acknowledge a playback read at 0x0800000 -> one pulse and fill_half = 0.
- Underrun: with fill_half = 1 and ld_done = 0, issue pb_req at 0x0800000 -> underrun = 1 and it stays 1 after later valid reads.
